program_load_ctrl: RTL

Sequencer for the instruction-fetch datapath and its instruction memory. It assembles a program from a byte stream (debug UART side) into 32-bit words and writes them into instruction memory. It holds the pipeline in reset while loading, then gates pipeline advance in run or single-step mode until the pipeline reports a halt. It sits between the debug unit and the fetch stage, driving the memory write port and the pipeline enable/reset.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/byte_word_assembler.sv | 35 +++
 rtl/program_load_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the instruction-fetch side: word width, memory defaults
// and the program-load sequencer state encoding.
package mips_pkg;

  localparam int               LEN                    = 32;
  localparam int               DEFAULT_DEPTH          = 2048;
  localparam int               DEFAULT_ADDR_W         = 11;
  localparam logic [LEN-1:0]   DEFAULT_HALT_WORD      = 32'hFFFF_FFFF;
  localparam int               DEFAULT_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects four bytes MSB-first into one instruction word and flags the byte
// that completes it.
module byte_word_assembler
  import mips_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_accept,
  input  logic [7:0]     i_byte,
  output logic [LEN-1:0] o_word,
  output logic           o_word_done,
  output logic           o_partial
);

  logic [1:0] byte_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rst)        byte_idx <= '0;
    else if (i_clear)  byte_idx <= '0;
    else if (i_accept) byte_idx <= byte_idx + 2'd1;
  end

  // NOTE: the shift register is pure datapath and has no reset; byte_idx alone
  // decides when its contents are meaningful.
  always_ff @(posedge i_clk) begin
    if (i_accept) o_word <= {o_word[LEN-9:0], i_byte};
  end

  assign o_word_done = i_accept && (byte_idx == 2'd3);
  assign o_partial   = (byte_idx != 2'd0);

endmodule

// File: rtl/program_load_ctrl.sv
// Loads a byte-streamed program into instruction memory, then gates the pipeline
// in run / single-step mode until HALT. Optional macro: PROGRAM_LOAD_TIMEOUT_EN.
module program_load_ctrl
  import mips_pkg::*;
#(
  parameter int             RAM_DEPTH_PROGRAM = DEFAULT_DEPTH,
  parameter int             ADDR_W            = DEFAULT_ADDR_W,
  parameter logic [LEN-1:0] HALT_WORD         = DEFAULT_HALT_WORD,
  parameter int             TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_cmd_run,
  input  logic              i_cmd_step,
  input  logic              i_cmd_load,
  input  logic              i_halt_seen,
  output logic              o_mem_wea,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LEN-1:0]    o_mem_data,
  output logic              o_pipe_en,
  output logic              o_pipe_rst,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_overflow,
  output logic [31:0]       o_cycle_count,
  output logic [2:0]        o_state
);

  state_t         state, state_nxt;
  logic           accept, word_done, partial, load_restart, timeout_flush;
  logic [LEN-1:0] word;
  logic           last_addr;

  assign accept       = i_rx_valid && (state == ST_LOAD);
  assign load_restart = (state == ST_DONE) && i_cmd_load;
  assign last_addr    = (o_word_count[ADDR_W-1:0] == ADDR_W'(RAM_DEPTH_PROGRAM - 1));

  byte_word_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (load_restart || timeout_flush),
    .i_accept    (accept),
    .i_byte      (i_rx_data),
    .o_word      (word),
    .o_word_done (word_done),
    .o_partial   (partial)
  );

`ifdef PROGRAM_LOAD_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout_flush = (state == ST_LOAD) && partial && !accept &&
                         (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst)
      idle_cnt <= '0;
    else if ((state != ST_LOAD) || !partial || accept || timeout_flush)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`else
  logic timeout_unused;
  assign timeout_flush  = 1'b0;
  assign timeout_unused = ^{32'(TIMEOUT_CYCLES), partial};
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state before the case so no path
  // leaves state_nxt unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (word_done) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ((word == HALT_WORD) || last_addr) ? ST_READY : ST_LOAD;
      ST_READY: begin
        if (i_cmd_run)       state_nxt = ST_RUN;
        else if (i_cmd_step) state_nxt = ST_STEP;
      end
      ST_RUN:   if (i_halt_seen) state_nxt = ST_DONE;
      ST_STEP:  state_nxt = i_halt_seen ? ST_DONE : ST_READY;
      ST_DONE:  if (i_cmd_load) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  assign o_rx_ready = (state == ST_LOAD);
  assign o_mem_wea  = (state == ST_WRITE);
  assign o_mem_addr = o_word_count[ADDR_W-1:0];
  assign o_mem_data = word;
  assign o_pipe_en  = (state == ST_RUN) || (state == ST_STEP);
  assign o_pipe_rst = (state != ST_LOAD) && (state != ST_WRITE);
  assign o_state    = state;

  // A HALT word landing in the last slot is a complete program, not an overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_word_count  <= '0;
      o_overflow    <= 1'b0;
      o_cycle_count <= '0;
    end else if (load_restart) begin
      o_word_count  <= '0;
      o_overflow    <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      if (state == ST_WRITE) begin
        o_word_count <= o_word_count + 1'b1;
        if ((word != HALT_WORD) && last_addr) o_overflow <= 1'b1;
      end
      if (o_pipe_en) o_cycle_count <= o_cycle_count + 32'd1;
    end
  end

endmodule
